// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving an 8-bit ALU over a START/BUSY/DONE handshake.
// Loops the ALU for MUL (repeated add) and SHRN (repeated shift).
module alu_sequencer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [2:0] OPCODE,
    input  logic [7:0] OPA,
    input  logic [7:0] OPB,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic       ALU_ADD,
    output logic       ALU_SUB,
    output logic       ALU_SHIFT,
    output logic       ALU_OR,
    output logic       ALU_AND,
    output logic       ALU_SETFLAGS,
    output logic [7:0] ALU_ACC,
    output logic [7:0] ALU_REG,
    input  logic [7:0] ALU_RESULT
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHR1 = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SHRN = 3'b111;

    logic [1:0] state;
    logic [2:0] op;
    logic [7:0] opa_q;
    logic [7:0] accum;
    logic [7:0] k;

    logic       entering;
    logic [2:0] entry_op;
    logic [7:0] entry_k;
    logic [7:0] entry_acc;
    logic [7:0] entry_reg;
    logic [4:0] strobe_next;

    assign BUSY = (state == S_ISSUE) || (state == S_WAIT);

    // Operands and strobes are registered on the edge that enters ISSUE.
    always_comb begin
        entering  = 1'b0;
        entry_op  = op;
        entry_k   = k - 8'd1;
        entry_acc = ALU_ACC;
        entry_reg = ALU_RESULT;
        case (state)
            S_IDLE: begin
                entering  = START;
                entry_op  = OPCODE;
                entry_k   = 8'd1;
                entry_acc = OPA;
                entry_reg = OPB;
                case (OPCODE)
                    OP_SUB, OP_CMP: begin
                        entry_acc = OPB;
                        entry_reg = OPA;
                    end
                    OP_SHR1: begin
                        entry_acc = 8'd0;
                        entry_reg = OPA;
                    end
                    OP_MUL: begin
                        entry_k   = OPB;
                        entry_reg = 8'd0;
                    end
                    OP_SHRN: begin
                        entry_k   = {5'd0, OPB[2:0]};
                        entry_acc = 8'd0;
                        entry_reg = OPA;
                    end
                    default: ;
                endcase
            end
            S_WAIT:  entering = (k != 8'd1);
            default: entering = 1'b0;
        endcase
    end

    always_comb begin
        strobe_next = 5'd0;
        if (entry_k != 8'd0) begin
            case (entry_op)
                OP_ADD, OP_MUL:   strobe_next = 5'b00001;
                OP_SUB, OP_CMP:   strobe_next = 5'b00010;
                OP_SHR1, OP_SHRN: strobe_next = 5'b00100;
                OP_OR:            strobe_next = 5'b01000;
                default:          strobe_next = 5'b10000;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            op           <= OP_ADD;
            opa_q        <= 8'd0;
            accum        <= 8'd0;
            k            <= 8'd0;
            DONE         <= 1'b0;
            RESULT       <= 8'd0;
            ALU_ADD      <= 1'b0;
            ALU_SUB      <= 1'b0;
            ALU_SHIFT    <= 1'b0;
            ALU_OR       <= 1'b0;
            ALU_AND      <= 1'b0;
            ALU_SETFLAGS <= 1'b0;
            ALU_ACC      <= 8'd0;
            ALU_REG      <= 8'd0;
        end else begin
            DONE <= 1'b0;
            if (entering) begin
                {ALU_AND, ALU_OR, ALU_SHIFT, ALU_SUB, ALU_ADD} <= strobe_next;
                ALU_SETFLAGS <= (entry_k == 8'd1);
                ALU_ACC      <= entry_acc;
                ALU_REG      <= entry_reg;
            end else begin
                {ALU_AND, ALU_OR, ALU_SHIFT, ALU_SUB, ALU_ADD} <= 5'd0;
                ALU_SETFLAGS <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (START) begin
                        op    <= OPCODE;
                        opa_q <= OPA;
                        accum <= (OPCODE == OP_MUL) ? 8'd0 : OPA;
                        k     <= entry_k;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (k == 8'd0) begin
                        RESULT <= accum;
                        DONE   <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    accum <= ALU_RESULT;
                    k     <= k - 8'd1;
                    if (k == 8'd1) begin
                        // CMP only updates flags; it reports its first operand.
                        RESULT <= (op == OP_CMP) ? opa_q : ALU_RESULT;
                        DONE   <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sits between instruction decode and the 8-bit ALU. It accepts one command at a time over a START/BUSY/DONE handshake and drives the ALU's one-hot operation strobes, operand buses and SetFlags. It captures the ALU's registered result, and loops the ALU for multi-pass operations (multiply by repeated add, multi-bit right shift). The final 8-bit value is returned on RESULT with a one-cycle DONE pulse.

## Interface
No parameters; data width fixed at 8.
- CLK  in  1  sole clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  command valid; sampled only when BUSY=0
- OPCODE  in  3  000 ADD, 001 SUB, 010 SHR1, 011 OR, 100 AND, 101 CMP, 110 MUL, 111 SHRN
- OPA  in  8  first operand, latched on acceptance
- OPB  in  8  second operand / iteration count, latched on acceptance
- BUSY  out  1  high from the cycle after acceptance until DONE cycle (exclusive)
- DONE  out  1  one-cycle pulse; RESULT valid in that cycle
- RESULT  out  8  registered result; holds until the next DONE
- ALU_ADD, ALU_SUB, ALU_SHIFT, ALU_OR, ALU_AND  out  1 each  one-hot strobes to ALU
- ALU_SETFLAGS  out  1  ALU flag-register update enable
- ALU_ACC  out  8  ALU ACC operand
- ALU_REG  out  8  ALU REG operand
- ALU_RESULT  in  8  ALU registered result; valid the cycle after a strobe

## Operation
- ALU contract:
  - ALU registers its result on the edge ending a strobe cycle.
  - SUB computes REG − ACC (two's complement: ~ACC + REG + 1).
  - SHIFT computes REG >> 1.
- States: IDLE, ISSUE, WAIT.
- IDLE: BUSY=0.
  - START=1 latches OPCODE/OPA/OPB, loads iteration count k, loads accumulator ACCUM, then goes to ISSUE.
- ISSUE:
  - If remaining k=0: RESULT<=ACCUM, DONE<=1, go to IDLE; no strobe, no flag update.
  - Else assert exactly one strobe and drive operands per opcode, then go to WAIT.
- WAIT: no strobe.
  - ACCUM<=ALU_RESULT and k<=k−1.
  - If the new k=0: RESULT<=ACCUM value (CMP: OPA), DONE<=1, go to IDLE.
  - Else go to ISSUE.
- Per-opcode setup (k, initial ACCUM, strobe, ALU_ACC, ALU_REG):
  - ADD: k=1, ADD, ACC=OPA, REG=OPB.
  - SUB (OPA−OPB): k=1, SUB, ACC=OPB, REG=OPA.
  - SHR1: k=1, SHIFT, REG=OPA, ACC=0.
  - OR / AND: k=1, ACC=OPA, REG=OPB.
  - CMP: k=1, SUB, ACC=OPB, REG=OPA; RESULT=OPA (ALU output discarded); purpose is flag update.
  - MUL: k=OPB, ACCUM=0, ADD, ACC=OPA, REG=ACCUM; result is (OPA·OPB) mod 256.
  - SHRN: k=OPB[2:0], ACCUM=OPA, SHIFT, REG=ACCUM.
- ALU_SETFLAGS=1 only in the ISSUE cycle of the last iteration (k=1 on entry), for all opcodes.
- Strobes and SETFLAGS are zero outside ISSUE. ALU_ACC/ALU_REG hold their ISSUE values through WAIT.
- START while BUSY=1 is ignored (not queued). START in the DONE cycle is accepted (BUSY=0 then).
- Illegal states recover to IDLE.

## Timing
- Acceptance edge = E0.
- Latency to DONE high:
  - k≥1: DONE high in the cycle after edge E0+2k.
  - k=0 (MUL with OPB=0, SHRN with OPB[2:0]=0): DONE high after E0+1.
- Single ops: DONE 2 cycles after acceptance. Back-to-back throughput: one op per 3 cycles.
- MUL worst case: OPB=255 gives 510 cycles.
- Reset values:
  - state IDLE, BUSY=0, DONE=0, RESULT=0x00.
  - all strobes and ALU_SETFLAGS=0, ALU_ACC=ALU_REG=0x00.
  - ACCUM=0, k=0.
- Reset mid-operation: aborts in the next cycle with no DONE and RESULT cleared. ALU flags are untouched because no SETFLAGS is issued.
- RST has priority over START in the same cycle.
- Arithmetic wraps mod 256; carry/borrow are reported only through ALU flags.

## Test plan
- Reset, then ADD OPA=0x7F, OPB=0x01 -> ALU_ADD pulse 1 cycle after E0 with SETFLAGS=1; DONE 2 cycles after E0, RESULT=0x80, BUSY high exactly 2 cycles.
- SUB 0x05−0x07, then CMP 0x33/0x33 issued the DONE cycle later -> SUB RESULT=0xFE. CMP is accepted in the SUB DONE cycle, gives RESULT=0x33, and shows one SUB strobe with SETFLAGS.
- MUL OPA=0x13, OPB=0x0E -> 14 ADD strobes, SETFLAGS only on the 14th, DONE after E0+28, RESULT=0x0A (266 mod 256).
- MUL OPB=0 and SHRN OPB=0x08 -> no strobes, no SETFLAGS, DONE after E0+1, RESULT=0x00 and OPA respectively.
- SHRN OPA=0xF0, OPB=0x03 -> 3 SHIFT strobes, RESULT=0x1E. START pulsed during BUSY is ignored (exactly one DONE).
- MUL OPB=0x10 with RST asserted at E0+5 for 1 cycle -> BUSY=0, no DONE, RESULT=0x00 next cycle. A new ADD 0x01+0x02 then completes with RESULT=0x03.
